// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REQ, FILL, INSTALL} icache_state_t;

  localparam logic [31:0] ICACHE_NOP = 32'h00000013;

  // Byte-offset width of a line: word select plus the two byte bits.
  function automatic int unsigned offset_bits(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int unsigned index_bits(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned num_sets,
                                           input int unsigned line_words);
    return 32 - offset_bits(line_words) - index_bits(num_sets);
  endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Refill line buffer: collects in-order response beats and flags the final beat.
module icache_line_buffer #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  output logic [LINE_WORDS*32-1:0] line_out,
  output logic                     last_beat
);

  localparam int unsigned CntBits = $clog2(LINE_WORDS);

  logic [CntBits-1:0]          beat_cnt_q, beat_cnt_d;
  logic [LINE_WORDS-1:0][31:0] words_q;

  assign last_beat = (beat_cnt_q == CntBits'(LINE_WORDS - 1));
  assign line_out  = words_q;

  // The counter parks on the last beat and only returns to zero on clear.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clear) begin
      beat_cnt_d = '0;
    end else if (wr_en && !last_beat) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      words_q[beat_cnt_q] <= wr_data;
    end
  end

endmodule

// File: rtl/instr_cache_dm.sv
// Direct-mapped read-only L1 instruction cache with whole-line refill.
// Define ICACHE_STATS_EN to add the HitCount/MissCount statistics outputs.
module instr_cache_dm
  import icache_pkg::*;
#(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        InstrMissF,
  output logic        InstrCacheRepActive,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic [31:0] MemReqAddr,
  input  logic        MemRespValid,
  input  logic [31:0] MemRespData
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int unsigned OFFSET_BITS = offset_bits(LINE_WORDS);
  localparam int unsigned INDEX_BITS  = index_bits(NUM_SETS);
  localparam int unsigned TAG_BITS    = tag_bits(NUM_SETS, LINE_WORDS);
  localparam int unsigned WORD_BITS   = $clog2(LINE_WORDS);
  localparam int unsigned TAG_LSB     = OFFSET_BITS + INDEX_BITS;

  icache_state_t state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;

  logic [NUM_SETS-1:0]         valid_q;
  logic [TAG_BITS-1:0]         tag_q  [NUM_SETS];
  logic [LINE_WORDS-1:0][31:0] data_q [NUM_SETS];

  logic [WORD_BITS-1:0]     pc_word;
  logic [INDEX_BITS-1:0]    pc_index, fill_index;
  logic [TAG_BITS-1:0]      pc_tag;
  logic                     hit, in_idle, buf_wr, install, last_beat;
  logic [LINE_WORDS*32-1:0] line_flat;
  logic                     unused_pcf_bits;

  assign unused_pcf_bits = ^PCF[1:0];

  assign pc_word    = PCF[OFFSET_BITS-1:2];
  assign pc_index   = PCF[TAG_LSB-1:OFFSET_BITS];
  assign pc_tag     = PCF[31:TAG_LSB];
  assign fill_index = miss_addr_q[TAG_LSB-1:OFFSET_BITS];

  assign hit                 = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign in_idle             = (state_q == IDLE);
  assign InstrMissF          = !hit || !in_idle;
  assign InstrF              = InstrMissF ? ICACHE_NOP : data_q[pc_index][pc_word];
  assign InstrCacheRepActive = !in_idle;
  assign MemReqAddr          = miss_addr_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    MemReqValid = 1'b0;
    buf_wr      = 1'b0;
    install     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          miss_addr_d = {PCF[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          state_d     = REQ;
        end
      end
      REQ: begin
        MemReqValid = 1'b1;
        if (MemReqReady) state_d = FILL;
      end
      FILL: begin
        if (MemRespValid) begin
          buf_wr = 1'b1;
          if (last_beat) state_d = INSTALL;
        end
      end
      INSTALL: begin
        install = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (install) valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone gates their use.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_q[fill_index]  <= miss_addr_q[31:TAG_LSB];
      data_q[fill_index] <= line_flat;
    end
  end

  icache_line_buffer #(
    .LINE_WORDS(LINE_WORDS)
  ) u_line_buffer (
    .clk      (clk),
    .reset    (reset),
    .clear    (install),
    .wr_en    (buf_wr),
    .wr_data  (MemRespData),
    .line_out (line_flat),
    .last_beat(last_beat)
  );

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (in_idle && hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (in_idle && !hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instr_cache_dm.sv
// Directed bench for instr_cache_dm with a zero-wait line-fill memory model.
module tb_instr_cache_dm;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        InstrMissF, InstrCacheRepActive, MemReqValid, MemReqReady;
  logic [31:0] MemReqAddr;
  logic        MemRespValid;
  logic [31:0] MemRespData;
`ifdef ICACHE_STATS_EN
  logic [31:0] HitCount, MissCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_cache_dm #(
    .NUM_SETS  (64),
    .LINE_WORDS(4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .PCF                (PCF),
    .InstrF             (InstrF),
    .InstrMissF         (InstrMissF),
    .InstrCacheRepActive(InstrCacheRepActive),
    .MemReqValid        (MemReqValid),
    .MemReqReady        (MemReqReady),
    .MemReqAddr         (MemReqAddr),
    .MemRespValid       (MemRespValid),
    .MemRespData        (MemRespData)
`ifdef ICACHE_STATS_EN
    ,
    .HitCount           (HitCount),
    .MissCount          (MissCount)
`endif
  );

  // Memory word i of the line at base a.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int i);
    return 32'h1000 + (a >> 2) + 32'(i);
  endfunction

  // Memory model: handshake seen before an edge yields 4 beats starting that edge.
  initial begin
    logic        hs;
    logic [31:0] base;
    int          beats;
    int          idx;
    MemRespValid = 1'b0;
    MemRespData  = '0;
    beats = 0;
    idx   = 0;
    base  = '0;
    forever begin
      @(negedge clk);
      hs = MemReqValid && MemReqReady && !reset;
      if (hs) base = MemReqAddr;
      @(posedge clk);
      #2;
      if (reset) beats = 0;
      if (hs && !reset) begin
        beats = 4;
        idx   = 0;
      end
      if (beats > 0) begin
        MemRespValid = 1'b1;
        MemRespData  = mem_word(base, idx);
        idx++;
        beats--;
      end else begin
        MemRespValid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs until a hit; hit_at is the sample index of the hit (-1 if the budget expires).
  task automatic wait_refill(output int hit_at, output logic [31:0] addr, output int rep);
    hit_at = -1;
    addr   = 32'hFFFF_FFFF;
    rep    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (MemReqValid) addr = MemReqAddr;
      if (InstrCacheRepActive) rep++;
      if (!InstrMissF) begin
        hit_at = i;
        return;
      end
      next_cycle();
    end
  endtask

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          hit_at, rep, gap, gap_at;
    logic [31:0] addr;

    vecs[0] = '{32'h0000_0004, 32'h0000_1001};
    vecs[1] = '{32'h0000_0008, 32'h0000_1002};
    vecs[2] = '{32'h0000_000C, 32'h0000_1003};
    vecs[3] = '{32'h0000_000E, 32'h0000_1003};
    vecs[4] = '{32'h0000_0000, 32'h0000_1000};
    vecs[5] = '{32'h0000_0080, 32'h0000_1020};
    vecs[6] = '{32'h0000_008C, 32'h0000_1023};
    vecs[7] = '{32'h0000_0000, 32'h0000_1000};
    vecs[8] = '{32'h0000_0014, 32'h0000_1005};

    reset       = 1'b1;
    PCF         = '0;
    MemReqReady = 1'b1;
    next_cycle();
    next_cycle();

    // Reset state
    @(negedge clk);
    check("rst_miss", 32'(InstrMissF), 32'd1);
    check("rst_rep", 32'(InstrCacheRepActive), 32'd0);
    check("rst_instr", InstrF, NOP);
    check("rst_reqv", 32'(MemReqValid), 32'd0);
    check("rst_reqaddr", MemReqAddr, 32'h0);

    // Cold miss at 0x0: IDLE detect cycle + REQ + 4 FILL + INSTALL
    next_cycle();
    reset = 1'b0;
    wait_refill(hit_at, addr, rep);
    check("t1_hit_at", 32'(hit_at), 32'd7);
    check("t1_rep_cycles", 32'(rep), 32'd6);
    check("t1_addr", addr, 32'h0);
    check("t1_instr", InstrF, 32'h0000_1000);

    // Hits within the freshly filled line
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      PCF = vecs[i].pcf;
      @(negedge clk);
      check($sformatf("vec%0d_instr", i), InstrF, vecs[i].instr);
      check($sformatf("vec%0d_miss", i), 32'(InstrMissF), 32'd0);
      check($sformatf("vec%0d_reqv", i), 32'(MemReqValid), 32'd0);
    end

    // Conflict miss on the same set
    next_cycle();
    PCF = 32'h400;
    wait_refill(hit_at, addr, rep);
    check("t3_hit_at", 32'(hit_at), 32'd7);
    check("t3_addr", addr, 32'h400);
    check("t3_instr", InstrF, 32'h0000_1100);
    next_cycle();
    PCF = 32'h0;
    @(negedge clk);
    check("t3_remiss", 32'(InstrMissF), 32'd1);
    check("t3_remiss_instr", InstrF, NOP);

    // Redirect to 0x80 two cycles into the fill of line 0x0
    next_cycle();
    @(negedge clk);
    check("t5_reqv", 32'(MemReqValid), 32'd1);
    check("t5_reqaddr", MemReqAddr, 32'h0);
    next_cycle();
    next_cycle();
    PCF    = 32'h80;
    gap    = 0;
    gap_at = -1;
    hit_at = -1;
    addr   = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (MemReqValid) addr = MemReqAddr;
      if (!InstrCacheRepActive && InstrMissF) begin
        gap++;
        gap_at = i;
      end
      if (!InstrMissF) begin
        hit_at = i;
        break;
      end
      next_cycle();
    end
    check("t5_hit_at", 32'(hit_at), 32'd11);
    check("t5_gap_cycles", 32'(gap), 32'd1);
    check("t5_gap_at", 32'(gap_at), 32'd4);
    check("t5_addr", addr, 32'h80);
    check("t5_instr", InstrF, 32'h0000_1020);

    // Request held off for five cycles
    next_cycle();
    PCF         = 32'h10;
    MemReqReady = 1'b0;
    @(negedge clk);
    check("t4_miss", 32'(InstrMissF), 32'd1);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d_reqv", k), 32'(MemReqValid), 32'd1);
      check($sformatf("t4_hold%0d_addr", k), MemReqAddr, 32'h10);
      next_cycle();
    end
    MemReqReady = 1'b1;
    @(negedge clk);
    check("t4_hs_reqv", 32'(MemReqValid), 32'd1);
    next_cycle();
    @(negedge clk);
    check("t4_fill_reqv", 32'(MemReqValid), 32'd0);
    check("t4_fill_rep", 32'(InstrCacheRepActive), 32'd1);
    next_cycle();
    wait_refill(hit_at, addr, rep);
    check("t4_hit_at", 32'(hit_at), 32'd4);
    check("t4_instr", InstrF, 32'h0000_1004);

    // Lines installed by the redirect and held-off tests
    for (int i = 5; i < 9; i++) begin
      next_cycle();
      PCF = vecs[i].pcf;
      @(negedge clk);
      check($sformatf("vec%0d_instr", i), InstrF, vecs[i].instr);
      check($sformatf("vec%0d_miss", i), 32'(InstrMissF), 32'd0);
      check($sformatf("vec%0d_reqv", i), 32'(MemReqValid), 32'd0);
    end

    // Reset in the middle of a fill
    next_cycle();
    PCF = 32'h200;
    @(negedge clk);
    check("t6_miss", 32'(InstrMissF), 32'd1);
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    PCF   = 32'h0;
    next_cycle();
    @(negedge clk);
    check("t6_rst_miss", 32'(InstrMissF), 32'd1);
    check("t6_rst_rep", 32'(InstrCacheRepActive), 32'd0);
    check("t6_rst_reqv", 32'(MemReqValid), 32'd0);
    check("t6_rst_addr", MemReqAddr, 32'h0);
    check("t6_rst_instr", InstrF, NOP);
    next_cycle();
    reset = 1'b0;
    wait_refill(hit_at, addr, rep);
    check("t6_hit_at", 32'(hit_at), 32'd7);
    check("t6_addr", addr, 32'h0);
    check("t6_instr", InstrF, 32'h0000_1000);
`ifdef ICACHE_STATS_EN
    check("t6_miss_count", MissCount, 32'd1);
    check("t6_hit_count", HitCount, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t6_hit_count_after", HitCount, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
